// File: rtl/universal_shift_reg_n.sv
// Parametrised universal shift register: logical/arithmetic shifts, rotates,
// parallel load and a multi-cycle burst rotate with Busy/Done handshake. WIDTH >= 2.
module universal_shift_reg_n #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    localparam int              CW          = $clog2(WIDTH) + 1
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Enable,
    input  logic [2:0]       Mode,
    input  logic             SerialIn,
    input  logic [WIDTH-1:0] Block,
    input  logic [CW-1:0]    Amount,
    input  logic             BurstLeft,
    output logic [WIDTH-1:0] Y,
    output logic             SerialOutLsb,
    output logic             SerialOutMsb,
    output logic             Busy,
    output logic             Done
);

    // state | meaning
    // IDLE  | single-cycle modes accepted; burst start sampled here
    // RUN   | burst rotation in progress, one bit per clock, inputs ignored
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_SHR   = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_LOAD  = 3'b011;
    localparam logic [2:0] MODE_ROR   = 3'b100;
    localparam logic [2:0] MODE_ROL   = 3'b101;
    localparam logic [2:0] MODE_ASR   = 3'b110;
    localparam logic [2:0] MODE_BURST = 3'b111;

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             dir_left, dir_left_nxt;
    logic [WIDTH-1:0] y_nxt;
    logic             done_nxt;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            dir_left <= 1'b0;
            Y        <= RESET_VALUE;
            Busy     <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            dir_left <= dir_left_nxt;
            Y        <= y_nxt;
            Busy     <= (state_nxt == RUN);
            Done     <= done_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        dir_left_nxt = dir_left;
        y_nxt        = Y;
        done_nxt     = 1'b0;
        unique case (state)
            IDLE: begin
                if (Enable) begin
                    case (Mode)
                        MODE_HOLD: y_nxt = Y;
                        MODE_SHR:  y_nxt = {SerialIn, Y[WIDTH-1:1]};
                        MODE_SHL:  y_nxt = {Y[WIDTH-2:0], SerialIn};
                        MODE_LOAD: y_nxt = Block;
                        MODE_ROR:  y_nxt = {Y[0], Y[WIDTH-1:1]};
                        MODE_ROL:  y_nxt = {Y[WIDTH-2:0], Y[WIDTH-1]};
                        MODE_ASR:  y_nxt = {Y[WIDTH-1], Y[WIDTH-1:1]};
                        MODE_BURST: begin
                            cnt_nxt      = Amount;
                            dir_left_nxt = BurstLeft;
                            // A zero-length burst completes immediately without entering RUN
                            if (Amount == '0) begin
                                done_nxt = 1'b1;
                            end else begin
                                state_nxt = RUN;
                            end
                        end
                        default: y_nxt = Y;
                    endcase
                end
            end
            RUN: begin
                y_nxt   = dir_left ? {Y[WIDTH-2:0], Y[WIDTH-1]} : {Y[0], Y[WIDTH-1:1]};
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign SerialOutLsb = Y[0];
    assign SerialOutMsb = Y[WIDTH-1];

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Directed bench for universal_shift_reg_n: vector table on an 8-bit instance,
// hand sequences for bursts/reset abort, and 4/16-bit instances for parametrisation.
module tb_universal_shift_reg_n;

    logic        Clock = 1'b0;
    logic        rst_n;
    logic [2:0]  mode;
    logic        serial_in;
    logic        burst_left;

    logic        en8, en4, en16;
    logic [7:0]  blk8;
    logic [3:0]  blk4;
    logic [15:0] blk16;
    logic [3:0]  amt8;
    logic [2:0]  amt4;
    logic [4:0]  amt16;
    logic [7:0]  y8;
    logic [3:0]  y4;
    logic [15:0] y16;
    logic        lsb8, msb8, busy8, done8;
    logic        lsb4, msb4, busy4, done4;
    logic        lsb16, msb16, busy16, done16;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    universal_shift_reg_n #(.WIDTH(8)) dut8 (
        .Clock(Clock), .Reset_n(rst_n), .Enable(en8), .Mode(mode), .SerialIn(serial_in),
        .Block(blk8), .Amount(amt8), .BurstLeft(burst_left), .Y(y8),
        .SerialOutLsb(lsb8), .SerialOutMsb(msb8), .Busy(busy8), .Done(done8));

    universal_shift_reg_n #(.WIDTH(4), .RESET_VALUE(4'h9)) dut4 (
        .Clock(Clock), .Reset_n(rst_n), .Enable(en4), .Mode(mode), .SerialIn(serial_in),
        .Block(blk4), .Amount(amt4), .BurstLeft(burst_left), .Y(y4),
        .SerialOutLsb(lsb4), .SerialOutMsb(msb4), .Busy(busy4), .Done(done4));

    universal_shift_reg_n #(.WIDTH(16), .RESET_VALUE(16'hBEEF)) dut16 (
        .Clock(Clock), .Reset_n(rst_n), .Enable(en16), .Mode(mode), .SerialIn(serial_in),
        .Block(blk16), .Amount(amt16), .BurstLeft(burst_left), .Y(y16),
        .SerialOutLsb(lsb16), .SerialOutMsb(msb16), .Busy(busy16), .Done(done16));

    typedef struct {
        logic       rst_n;
        logic       en;
        logic [2:0] mode;
        logic       si;
        logic [7:0] blk;
        logic [3:0] amt;
        logic       bl;
        logic [7:0] y;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] y, input logic busy, input logic done);
        check({tag, " y"}, 32'(y8), 32'(y));
        check({tag, " busy"}, 32'(busy8), 32'(busy));
        check({tag, " done"}, 32'(done8), 32'(done));
        check({tag, " lsb"}, 32'(lsb8), 32'(y[0]));
        check({tag, " msb"}, 32'(msb8), 32'(y[7]));
    endtask

    function automatic logic [7:0] ror8(input logic [7:0] v);
        return {v[0], v[7:1]};
    endfunction

    initial begin
        logic [7:0] exp_y;
        int n;

        rst_n = 1'b0; mode = 3'b000; serial_in = 1'b0; burst_left = 1'b0;
        en8 = 1'b0; en4 = 1'b0; en16 = 1'b0;
        blk8 = '0; blk4 = '0; blk16 = '0; amt8 = '0; amt4 = '0; amt16 = '0;

        //                rst en  mode   si   blk    amt   bl    y      busy done
        vecs.push_back('{1'b0, 1'b0, 3'b000, 1'b0, 8'h00, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b0, 1'b1, 3'b011, 1'b0, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b011, 1'b0, 8'hFF, 4'd0, 1'b0, 8'h00, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b011, 1'b0, 8'hA5, 4'd0, 1'b0, 8'hA5, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b001, 1'b1, 8'h00, 4'd0, 1'b0, 8'hD2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 1'b0, 8'h00, 4'd0, 1'b0, 8'hA4, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b110, 1'b1, 8'h00, 4'd0, 1'b0, 8'hD2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b100, 1'b0, 8'h00, 4'd0, 1'b0, 8'h69, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b101, 1'b0, 8'h00, 4'd0, 1'b0, 8'hD2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b000, 1'b1, 8'hFF, 4'd0, 1'b0, 8'hD2, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b001, 1'b0, 8'h00, 4'd0, 1'b0, 8'h69, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b010, 1'b1, 8'h00, 4'd0, 1'b0, 8'hD3, 1'b0, 1'b0});
        for (int m = 0; m < 8; m++)
            vecs.push_back('{1'b1, 1'b0, 3'(m), 1'b1, 8'h3C, 4'd3, 1'b1, 8'hD3, 1'b0, 1'b0});
        // zero-length bursts: immediate Done, never Busy, back-to-back allowed
        vecs.push_back('{1'b1, 1'b1, 3'b111, 1'b0, 8'h00, 4'd0, 1'b1, 8'hD3, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b0, 3'b000, 1'b0, 8'h00, 4'd0, 1'b0, 8'hD3, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b111, 1'b0, 8'h00, 4'd0, 1'b0, 8'hD3, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 3'b111, 1'b0, 8'h00, 4'd0, 1'b0, 8'hD3, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 4'd0, 1'b0, 8'hD3, 1'b0, 1'b0});
        // burst left by 3 on 81, inputs toggled while Busy
        vecs.push_back('{1'b1, 1'b1, 3'b011, 1'b0, 8'h81, 4'd0, 1'b0, 8'h81, 1'b0, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b111, 1'b0, 8'h00, 4'd3, 1'b1, 8'h81, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b011, 1'b1, 8'hFF, 4'd0, 1'b0, 8'h03, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b1, 3'b001, 1'b1, 8'h55, 4'd7, 1'b0, 8'h06, 1'b1, 1'b0});
        vecs.push_back('{1'b1, 1'b0, 3'b111, 1'b0, 8'hAA, 4'd2, 1'b0, 8'h0C, 1'b0, 1'b1});
        vecs.push_back('{1'b1, 1'b1, 3'b000, 1'b0, 8'h00, 4'd0, 1'b0, 8'h0C, 1'b0, 1'b0});

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n = vecs[i].rst_n; en8 = vecs[i].en; mode = vecs[i].mode;
            serial_in = vecs[i].si; blk8 = vecs[i].blk; amt8 = vecs[i].amt;
            burst_left = vecs[i].bl;
            tick();
            check8($sformatf("vec[%0d]", i), vecs[i].y, vecs[i].busy, vecs[i].done);
        end

        // burst right by 9 on 01 (more than WIDTH), then back-to-back start in the Done cycle
        en8 = 1'b1; mode = 3'b011; blk8 = 8'h01; tick();
        mode = 3'b111; amt8 = 4'd9; burst_left = 1'b0; tick();
        check8("b9 start", 8'h01, 1'b1, 1'b0);
        exp_y = 8'h01;
        for (int i = 1; i <= 9; i++) begin
            mode = 3'(i); blk8 = 8'(i * 37); amt8 = 4'(i); burst_left = i[0];
            if (i == 9) begin
                mode = 3'b111; amt8 = 4'd1; burst_left = 1'b1;
            end
            tick();
            exp_y = ror8(exp_y);
            check8($sformatf("b9 step%0d", i), exp_y, i < 9, i == 9);
        end
        check("b9 final", 32'(y8), 32'h80);
        mode = 3'b111; amt8 = 4'd1; burst_left = 1'b1; tick();
        check8("b2b start", 8'h80, 1'b1, 1'b0);
        mode = 3'b000; tick();
        check8("b2b done", 8'h01, 1'b0, 1'b1);
        tick();
        check8("b2b after", 8'h01, 1'b0, 1'b0);

        // reset during the third Busy cycle aborts the burst without Done
        mode = 3'b011; blk8 = 8'h0F; tick();
        mode = 3'b111; amt8 = 4'd5; burst_left = 1'b1; tick();
        check8("abort busy1", 8'h0F, 1'b1, 1'b0);
        tick();
        check8("abort busy2", 8'h1E, 1'b1, 1'b0);
        tick();
        check8("abort busy3", 8'h3C, 1'b1, 1'b0);
        rst_n = 1'b0; tick();
        check8("abort reset", 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1; en8 = 1'b0; mode = 3'b000;
        for (int i = 0; i < 6; i++) begin
            tick();
            check8($sformatf("abort quiet%0d", i), 8'h00, 1'b0, 1'b0);
        end
        check("w4 reset y", 32'(y4), 32'h9);
        check("w16 reset y", 32'(y16), 32'hBEEF);
        check("w4 reset busy", 32'(busy4), 32'h0);
        check("w16 reset done", 32'(done16), 32'h0);

        // WIDTH=4
        en4 = 1'b1; mode = 3'b011; blk4 = 4'hA; tick();
        check("w4 load", 32'(y4), 32'hA);
        mode = 3'b001; serial_in = 1'b1; tick();
        check("w4 shr", 32'(y4), 32'hD);
        check("w4 shr msb", 32'(msb4), 32'h1);
        check("w4 shr lsb", 32'(lsb4), 32'h1);
        mode = 3'b010; serial_in = 1'b0; tick();
        check("w4 shl", 32'(y4), 32'hA);
        check("w4 shl lsb", 32'(lsb4), 32'h0);
        mode = 3'b110; serial_in = 1'b0; tick();
        check("w4 asr", 32'(y4), 32'hD);
        mode = 3'b100; tick();
        check("w4 ror", 32'(y4), 32'hE);
        mode = 3'b111; amt4 = 3'd7; burst_left = 1'b1; tick();
        check("w4 burst busy", 32'(busy4), 32'h1);
        mode = 3'b000;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            n++;
            if (done4) break;
        end
        check("w4 burst cycles", 32'(n), 32'd7);
        check("w4 burst y", 32'(y4), 32'h7);
        check("w4 burst busy end", 32'(busy4), 32'h0);
        en4 = 1'b0;

        // WIDTH=16
        en16 = 1'b1; mode = 3'b011; blk16 = 16'hA5C3; tick();
        check("w16 load", 32'(y16), 32'hA5C3);
        mode = 3'b001; serial_in = 1'b1; tick();
        check("w16 shr", 32'(y16), 32'hD2E1);
        check("w16 shr msb", 32'(msb16), 32'h1);
        mode = 3'b010; serial_in = 1'b0; tick();
        check("w16 shl", 32'(y16), 32'hA5C2);
        check("w16 shl lsb", 32'(lsb16), 32'h0);
        mode = 3'b110; tick();
        check("w16 asr", 32'(y16), 32'hD2E1);
        mode = 3'b100; tick();
        check("w16 ror", 32'(y16), 32'hE970);
        mode = 3'b111; amt16 = 5'd31; burst_left = 1'b1; tick();
        check("w16 burst busy", 32'(busy16), 32'h1);
        mode = 3'b000;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            n++;
            if (done16) break;
        end
        check("w16 burst cycles", 32'(n), 32'd31);
        check("w16 burst y", 32'(y16), 32'h74B8);
        tick();
        check("w16 done pulse", 32'(done16), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
